// File: rtl/array_heap.sv
// Fixed-size pool of small arrays with allocate/free and element operations.
// Scans and shifts step one element per cycle; everything else completes in one step.
module array_heap #(
    parameter int ADDRESS_BITS = 2,
    parameter int INDEX_BITS   = 2,
    parameter int DATA_BITS    = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [7:0]              i_action,
    input  logic [ADDRESS_BITS-1:0] i_array,
    input  logic [INDEX_BITS-1:0]   i_index,
    input  logic [DATA_BITS-1:0]    i_in,
    output logic [DATA_BITS-1:0]    o_out,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [31:0]             o_error
);
    localparam int ARRAYS       = 2 ** ADDRESS_BITS;
    localparam int ARRAY_LENGTH = 2 ** INDEX_BITS;
    localparam int SW           = INDEX_BITS + 1;
    localparam int AW           = ADDRESS_BITS + 1;
    localparam logic [AW-1:0] NumArrays = AW'(ARRAYS);
    localparam logic [SW-1:0] ArrayLen  = SW'(ARRAY_LENGTH);

    localparam logic [7:0] ActReset = 8'd1,  ActWrite = 8'd2,   ActRead = 8'd3;
    localparam logic [7:0] ActSize  = 8'd4,  ActIndex = 8'd7,   ActLess = 8'd8;
    localparam logic [7:0] ActGreater = 8'd9, ActUp = 8'd10,    ActDown = 8'd11;
    localparam logic [7:0] ActPush  = 8'd14, ActPop   = 8'd15,  ActAlloc = 8'd18;
    localparam logic [7:0] ActFree  = 8'd19, ActAdd   = 8'd20;

    localparam logic [2:0] ErrOk = 3'd0, ErrNotAlloc = 3'd1, ErrBounds = 3'd2, ErrFull = 3'd3;
    localparam logic [2:0] ErrEmpty = 3'd4, ErrNoFree = 3'd5, ErrDouble = 3'd6, ErrAction = 3'd7;

    typedef enum logic [1:0] {StIdle, StScan, StShift, StDone} state_e;

    state_e                  r_state, w_state_next;
    logic [DATA_BITS-1:0]    r_mem [ARRAYS][ARRAY_LENGTH];
    logic [SW-1:0]           r_size [ARRAYS];
    logic [ARRAYS-1:0]       r_alloc;
    logic [ADDRESS_BITS-1:0] r_free_stack [ARRAYS];
    logic [AW-1:0]           r_free_cnt, r_next_new;
    logic [7:0]              r_action;
    logic [ADDRESS_BITS-1:0] r_array;
    logic [INDEX_BITS-1:0]   r_index;
    logic [DATA_BITS-1:0]    r_in, r_out;
    logic [SW-1:0]           r_pos;
    logic [2:0]              r_error;

    logic                    w_accept, w_alloc, w_shift_last, w_scan_last;
    logic [2:0]              w_err;
    logic [SW-1:0]           w_size, w_idx;
    logic [DATA_BITS-1:0]    w_elem, w_sum, w_scan_elem;
    logic [ADDRESS_BITS-1:0] w_alloc_num;

    assign w_accept    = (r_state == StIdle) && i_start;
    assign w_alloc     = r_alloc[i_array];
    assign w_size      = r_size[i_array];
    assign w_idx       = SW'(i_index);
    assign w_elem      = r_mem[i_array][i_index];
    assign w_sum       = w_elem + i_in;
    assign w_alloc_num = (r_free_cnt != '0) ? r_free_stack[ADDRESS_BITS'(r_free_cnt - AW'(1))]
                                            : ADDRESS_BITS'(r_next_new);
    assign w_scan_elem = r_mem[r_array][INDEX_BITS'(r_pos)];
    assign w_scan_last = (r_pos + SW'(1)) == r_size[r_array];
    assign w_shift_last = (r_action == ActUp) ? (r_pos == SW'(r_index) + SW'(1))
                                              : ((r_pos + SW'(2)) == r_size[r_array]);

    always_comb begin
        w_err = ErrOk;
        case (i_action)
            ActReset: w_err = ErrOk;
            ActAlloc: if (r_free_cnt == '0 && r_next_new == NumArrays) w_err = ErrNoFree;
            ActFree:  if (!w_alloc) w_err = ErrDouble;
            ActWrite, ActSize, ActIndex, ActLess, ActGreater:
                if (!w_alloc) w_err = ErrNotAlloc;
            ActRead, ActAdd, ActDown:
                if (!w_alloc) w_err = ErrNotAlloc;
                else if (w_idx >= w_size) w_err = ErrBounds;
            ActPush:
                if (!w_alloc) w_err = ErrNotAlloc;
                else if (w_size == ArrayLen) w_err = ErrFull;
            ActPop:
                if (!w_alloc) w_err = ErrNotAlloc;
                else if (w_size == '0) w_err = ErrEmpty;
            ActUp:
                if (!w_alloc) w_err = ErrNotAlloc;
                else if (w_idx > w_size) w_err = ErrBounds;
                else if (w_size == ArrayLen) w_err = ErrFull;
            default: w_err = ErrAction;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StDone;
                    if (w_err == ErrOk) begin
                        case (i_action)
                            ActIndex, ActLess, ActGreater:
                                if (w_size != '0) w_state_next = StScan;
                            ActUp:   if (w_size != w_idx) w_state_next = StShift;
                            ActDown: if (w_idx + SW'(1) != w_size) w_state_next = StShift;
                            default: w_state_next = StDone;
                        endcase
                    end
                end
            end
            StScan:  if (w_scan_last) w_state_next = StDone;
            StShift: if (w_shift_last) w_state_next = StDone;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int a = 0; a < ARRAYS; a++) begin
                for (int e = 0; e < ARRAY_LENGTH; e++) r_mem[a][e] <= '0;
                r_size[a]       <= '0;
                r_free_stack[a] <= '0;
            end
            r_alloc    <= '0;
            r_free_cnt <= '0;
            r_next_new <= '0;
            r_action   <= '0;
            r_array    <= '0;
            r_index    <= '0;
            r_in       <= '0;
            r_out      <= '0;
            r_pos      <= '0;
            r_error    <= ErrOk;
        end else begin
            case (r_state)
                StIdle: if (w_accept) begin
                    r_action <= i_action;
                    r_array  <= i_array;
                    r_index  <= i_index;
                    r_in     <= i_in;
                    r_out    <= '0;
                    r_pos    <= '0;
                    r_error  <= w_err;
                    if (w_err == ErrOk) begin
                        case (i_action)
                            ActReset: begin
                                for (int a = 0; a < ARRAYS; a++) begin
                                    for (int e = 0; e < ARRAY_LENGTH; e++) r_mem[a][e] <= '0;
                                    r_size[a] <= '0;
                                end
                                r_alloc    <= '0;
                                r_free_cnt <= '0;
                                r_next_new <= '0;
                            end
                            ActAlloc: begin
                                if (r_free_cnt != '0) r_free_cnt <= r_free_cnt - AW'(1);
                                else                  r_next_new <= r_next_new + AW'(1);
                                r_alloc[w_alloc_num] <= 1'b1;
                                r_size[w_alloc_num]  <= '0;
                                r_out <= DATA_BITS'(w_alloc_num);
                            end
                            ActFree: begin
                                r_free_stack[ADDRESS_BITS'(r_free_cnt)] <= i_array;
                                r_free_cnt       <= r_free_cnt + AW'(1);
                                r_alloc[i_array] <= 1'b0;
                                r_size[i_array]  <= '0;
                                for (int e = 0; e < ARRAY_LENGTH; e++) r_mem[i_array][e] <= '0;
                            end
                            ActWrite: begin
                                r_mem[i_array][i_index] <= i_in;
                                if (w_idx >= w_size) r_size[i_array] <= w_idx + SW'(1);
                                r_out <= i_in;
                            end
                            ActRead: r_out <= w_elem;
                            ActSize: r_out <= DATA_BITS'(w_size);
                            ActPush: begin
                                r_mem[i_array][INDEX_BITS'(w_size)] <= i_in;
                                r_size[i_array] <= w_size + SW'(1);
                                r_out <= i_in;
                            end
                            ActPop: begin
                                r_out <= r_mem[i_array][INDEX_BITS'(w_size - SW'(1))];
                                r_size[i_array] <= w_size - SW'(1);
                            end
                            ActUp: begin
                                r_out <= i_in;
                                if (w_size == w_idx) begin
                                    r_mem[i_array][i_index] <= i_in;
                                    r_size[i_array] <= w_size + SW'(1);
                                end else begin
                                    r_pos <= w_size;
                                end
                            end
                            ActDown: begin
                                r_out <= w_elem;
                                if (w_idx + SW'(1) == w_size) r_size[i_array] <= w_size - SW'(1);
                                else                          r_pos <= w_idx;
                            end
                            ActAdd: begin
                                r_mem[i_array][i_index] <= w_sum;
                                r_out <= w_sum;
                            end
                            default: ;
                        endcase
                    end
                end
                StScan: begin
                    r_pos <= r_pos + SW'(1);
                    case (r_action)
                        ActIndex:
                            if (r_out == '0 && w_scan_elem == r_in)
                                r_out <= DATA_BITS'(r_pos + SW'(1));
                        ActLess:    if (w_scan_elem < r_in) r_out <= r_out + DATA_BITS'(1);
                        ActGreater: if (w_scan_elem > r_in) r_out <= r_out + DATA_BITS'(1);
                        default: ;
                    endcase
                end
                StShift: begin
                    if (r_action == ActUp) begin
                        // Top-down so each source is read before it is overwritten.
                        r_mem[r_array][INDEX_BITS'(r_pos)] <=
                            r_mem[r_array][INDEX_BITS'(r_pos - SW'(1))];
                        r_pos <= r_pos - SW'(1);
                        if (w_shift_last) begin
                            r_mem[r_array][r_index] <= r_in;
                            r_size[r_array] <= r_size[r_array] + SW'(1);
                        end
                    end else begin
                        r_mem[r_array][INDEX_BITS'(r_pos)] <=
                            r_mem[r_array][INDEX_BITS'(r_pos + SW'(1))];
                        r_pos <= r_pos + SW'(1);
                        if (w_shift_last) r_size[r_array] <= r_size[r_array] - SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (r_state != StIdle);
    assign o_done  = (r_state == StDone);
    assign o_out   = r_out;
    assign o_error = {29'd0, r_error};
endmodule
